// File: rtl/fsmd_seq_datapath.sv
// fsmd_seq_datapath: multi-cycle compute unit for R3 = (a+b)*(c+d) +/- e.
// One shared adder forms the two sums. An iterative shift-add multiplier then
// forms the product, one bit per cycle. Work starts on start and finishes with
// a one-cycle done pulse. PS/NS are exposed so the sequencing can be debugged.
module fsmd_seq_datapath #(
  parameter int W  = 4,
  parameter int SW = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            mode,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [W-1:0]    c,
  input  logic [W-1:0]    d,
  input  logic [W-1:0]    e,
  output logic [W-1:0]    R1,
  output logic [W-1:0]    R2,
  output logic [2*W-1:0]  R3,
  output logic [SW-1:0]   PS,
  output logic [SW-1:0]   NS,
  output logic            busy,
  output logic            done
);

  // Counter wide enough to index every multiplier bit (at least one bit).
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [SW-1:0] {
    IDLE = SW'(0),
    ADD1 = SW'(1),
    ADD2 = SW'(2),
    MUL  = SW'(3),
    FIN  = SW'(4),
    DONE = SW'(5)
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [W-1:0]    a_l;
  logic [W-1:0]    b_l;
  logic [W-1:0]    c_l;
  logic [W-1:0]    d_l;
  logic [W-1:0]    e_l;
  logic            mode_l;
  logic [2*W-1:0]  acc;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  e_ext;
  logic [2*W-1:0]  partial;

  assign e_ext   = {{W{1'b0}}, e_l};
  assign partial = {{W{1'b0}}, R1} << cnt;
  assign PS      = state;
  assign NS      = next_state;

  // Next-state logic. Abort cancels any active state. Illegal codes fall back to IDLE.
  always_comb begin
    next_state = IDLE;
    if (state != IDLE && abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = start ? ADD1 : IDLE;
        ADD1:    next_state = ADD2;
        ADD2:    next_state = MUL;
        MUL:     next_state = (cnt == CW'(W - 1)) ? FIN : MUL;
        FIN:     next_state = DONE;
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // State, registered status flags and datapath. An aborted cycle writes nothing.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      R1     <= '0;
      R2     <= '0;
      R3     <= '0;
      a_l    <= '0;
      b_l    <= '0;
      c_l    <= '0;
      d_l    <= '0;
      e_l    <= '0;
      mode_l <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      done  <= (next_state == DONE);
      if (state == IDLE || !abort) begin
        case (state)
          IDLE: begin
            if (start) begin
              a_l    <= a;
              b_l    <= b;
              c_l    <= c;
              d_l    <= d;
              e_l    <= e;
              mode_l <= mode;
            end
          end
          ADD1: R1 <= a_l + b_l;
          ADD2: begin
            R2  <= c_l + d_l;
            acc <= '0;
            cnt <= '0;
          end
          MUL: begin
            if (R2[cnt]) acc <= acc + partial;
            cnt <= cnt + CW'(1);
          end
          FIN: R3 <= mode_l ? (acc - e_ext) : (acc + e_ext);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fsmd_seq_datapath.sv
// tb_fsmd_seq_datapath: directed vectors for a W=4 and a W=8 instance.
// Each launch pushes its hand-computed R1/R2/R3 into a queue. Per-instance
// monitors pop and compare whenever done is seen.
module tb_fsmd_seq_datapath;

  typedef struct {
    int r1;
    int r2;
    int r3;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        start4, abort4, mode4;
  logic [3:0]  a4, b4, c4, d4, e4;
  logic [3:0]  r1_4, r2_4;
  logic [7:0]  r3_4;
  logic [2:0]  ps4, ns4;
  logic        busy4, done4;

  logic        start8, abort8, mode8;
  logic [7:0]  a8, b8, c8, d8, e8;
  logic [7:0]  r1_8, r2_8;
  logic [15:0] r3_8;
  logic [2:0]  ps8, ns8;
  logic        busy8, done8;

  int   errors = 0;
  int   checks = 0;
  exp_t exp4_q[$];
  exp_t exp8_q[$];

  fsmd_seq_datapath #(.W(4), .SW(3)) u4 (
    .clock(clock), .reset(reset), .start(start4), .abort(abort4), .mode(mode4),
    .a(a4), .b(b4), .c(c4), .d(d4), .e(e4),
    .R1(r1_4), .R2(r2_4), .R3(r3_4), .PS(ps4), .NS(ns4), .busy(busy4), .done(done4)
  );

  fsmd_seq_datapath #(.W(8), .SW(3)) u8 (
    .clock(clock), .reset(reset), .start(start8), .abort(abort8), .mode(mode8),
    .a(a8), .b(b8), .c(c8), .d(d8), .e(e8),
    .R1(r1_8), .R2(r2_8), .R3(r3_8), .PS(ps8), .NS(ns8), .busy(busy8), .done(done8)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard monitor for the W=4 instance
  always @(negedge clock) begin
    if (!reset && done4 === 1'b1) begin
      if (exp4_q.size() == 0) begin
        check_output("unexpected_done4", done4, 0);
      end else begin
        exp_t x;
        x = exp4_q.pop_front();
        check_output("sb4_R1", r1_4, x.r1);
        check_output("sb4_R2", r2_4, x.r2);
        check_output("sb4_R3", r3_4, x.r3);
      end
    end
  end

  // Scoreboard monitor for the W=8 instance
  always @(negedge clock) begin
    if (!reset && done8 === 1'b1) begin
      if (exp8_q.size() == 0) begin
        check_output("unexpected_done8", done8, 0);
      end else begin
        exp_t x;
        x = exp8_q.pop_front();
        check_output("sb8_R1", r1_8, x.r1);
        check_output("sb8_R2", r2_8, x.r2);
        check_output("sb8_R3", r3_8, x.r3);
      end
    end
  end

  task automatic apply_stimulus(input int av, input int bv, input int cv, input int dv,
                                input int ev, input bit m);
    a4 = 4'(av); b4 = 4'(bv); c4 = 4'(cv); d4 = 4'(dv); e4 = 4'(ev);
    mode4 = m;
    start4 = 1'b1;
  endtask

  // One start pulse on the W=4 instance. Index i below is "after launch edge + i".
  task automatic run_op(input int av, input int bv, input int cv, input int dv, input int ev,
                        input bit m, input int r1e, input int r2e, input int r3e,
                        input bit check_seq);
    int seq [9] = '{1, 2, 3, 3, 3, 3, 4, 5, 0};
    @(negedge clock);
    exp4_q.push_back('{r1e, r2e, r3e});
    apply_stimulus(av, bv, cv, dv, ev, m);
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      if (i == 0) start4 = 1'b0;
      if (check_seq) check_output($sformatf("ps_seq[%0d]", i), ps4, seq[i]);
      if (check_seq || i == 7) check_output($sformatf("done_at[%0d]", i), done4, (i == 7) ? 1 : 0);
    end
    check_output("ps_back_idle", ps4, 0);
  endtask

  initial begin
    reset = 1'b1;
    start4 = 0; abort4 = 0; mode4 = 0; a4 = 0; b4 = 0; c4 = 0; d4 = 0; e4 = 0;
    start8 = 0; abort8 = 0; mode8 = 0; a8 = 0; b8 = 0; c8 = 0; d8 = 0; e8 = 0;
    repeat (2) @(negedge clock);
    check_output("rst_R1", r1_4, 0);
    check_output("rst_R2", r2_4, 0);
    check_output("rst_R3", r3_4, 0);
    check_output("rst_PS", ps4, 0);
    check_output("rst_busy", busy4, 0);
    check_output("rst_done", done4, 0);
    check_output("rst_R3_w8", r3_8, 0);
    reset = 1'b0;

    // Basic add, subtract, overflow and underflow cases
    run_op(1, 2, 3, 4, 5, 1'b0, 3, 7, 26, 1'b1);
    run_op(1, 2, 3, 4, 5, 1'b1, 3, 7, 16, 1'b0);
    run_op(15, 15, 15, 15, 0, 1'b0, 14, 14, 196, 1'b0);
    run_op(0, 0, 0, 0, 5, 1'b1, 0, 0, 251, 1'b0);

    // Start held high: relaunch every 9 cycles; changing a mid-op is ignored
    @(negedge clock);
    repeat (3) exp4_q.push_back('{5, 2, 10});
    apply_stimulus(2, 3, 1, 1, 0, 1'b0);
    for (int k = 0; k <= 27; k++) begin
      @(negedge clock);
      if (k == 10) a4 = 4'd9;
      if (k == 17) a4 = 4'd2;
      if (k == 26) start4 = 1'b0;
      check_output($sformatf("hold_done[%0d]", k), done4,
                   (k == 7 || k == 16 || k == 25) ? 1 : 0);
      if (k == 16) check_output("busy_in_done", busy4, 1);
    end
    check_output("hold_ps_idle", ps4, 0);

    // Reset during the second MUL cycle
    @(negedge clock);
    apply_stimulus(1, 2, 3, 4, 5, 1'b0);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clock);
      if (k == 0) start4 = 1'b0;
      if (k == 3) begin
        check_output("pre_rst_ps_mul", ps4, 3);
        reset = 1'b1;
      end
    end
    check_output("midrst_R1", r1_4, 0);
    check_output("midrst_R2", r2_4, 0);
    check_output("midrst_R3", r3_4, 0);
    check_output("midrst_PS", ps4, 0);
    check_output("midrst_busy", busy4, 0);
    check_output("midrst_done", done4, 0);
    reset = 1'b0;
    run_op(1, 2, 3, 4, 5, 1'b0, 3, 7, 26, 1'b0);

    // Abort inside MUL: back to IDLE, no done, R3 keeps 26
    @(negedge clock);
    apply_stimulus(15, 15, 15, 15, 0, 1'b0);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clock);
      if (k == 0) start4 = 1'b0;
      if (k == 3) abort4 = 1'b1;
    end
    abort4 = 1'b0;
    check_output("abort_PS", ps4, 0);
    check_output("abort_R3", r3_4, 26);
    check_output("abort_done", done4, 0);
    check_output("abort_busy", busy4, 0);
    repeat (10) @(negedge clock);
    check_output("abort_R3_held", r3_4, 26);

    // Start and abort together in IDLE: start wins
    @(negedge clock);
    exp4_q.push_back('{3, 7, 16});
    apply_stimulus(1, 2, 3, 4, 5, 1'b1);
    abort4 = 1'b1;
    @(negedge clock);
    start4 = 1'b0;
    abort4 = 1'b0;
    check_output("start_wins_PS", ps4, 1);
    repeat (10) @(negedge clock);

    // W=8: 127*255 = 32385. The operand e is 8 bits wide, so 1000 becomes 1000 mod 256 = 232. 32385 + 232 = 32617.
    @(negedge clock);
    exp8_q.push_back('{127, 255, 32617});
    a8 = 8'd100; b8 = 8'd27; c8 = 8'd200; d8 = 8'd55; e8 = 8'd232; mode8 = 1'b0;
    start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0;
    check_output("w8_PS_add1", ps8, 1);
    repeat (14) @(negedge clock);
    check_output("w8_PS_idle", ps8, 0);

    check_output("sb4_pending", exp4_q.size(), 0);
    check_output("sb8_pending", exp8_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
